uc_sequencer_p: RTL
===================

Name: uc_sequencer_p

Overview:
- Parametrised next-generation microcode sequencer for the microcoded CPU.
- Holds the current microaddress that drives the microcode ROM, and computes the next microaddress each clock from an op, a selectable condition, a jump/map address, a return stack and a loop counter.
- Generalises the fixed 12-bit, four-op sequencer with configurable width and stack depth, multi-way condition select with polarity, an opcode map dispatch, a hardware loop counter, a stall input and stack error flags.

Parameters:
ADDR_WIDTH, 12, microaddress width
STACK_DEPTH, 4, return stack entries (>=1)
COUNT_WIDTH, 8, loop counter width (<= ADDR_WIDTH)
NUM_COND, 8, condition inputs; cond_sel width is clog2(NUM_COND)
RESET_ADDR, 0, microaddress after reset

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  1 = freeze all state this cycle
op  input  3  0 NEXT, 1 JUMP, 2 CALL, 3 RETURN, 4 MAP, 5 LDCNT, 6 LOOP, 7 HOLD
cond_sel  input  clog2(NUM_COND)  condition index; 0 = always true
cond_invert  input  1  invert the selected condition
cond_in  input  NUM_COND  condition vector; bit 0 ignored
din  input  ADDR_WIDTH  jump/call/loop target, or counter load value (low COUNT_WIDTH bits)
map_in  input  ADDR_WIDTH  opcode map ROM address for MAP
uc_address  output  ADDR_WIDTH  registered current microaddress
depth  output  clog2(STACK_DEPTH+1)  number of stack entries in use
count_zero  output  1  loop counter == 0
stack_overflow  output  1  sticky flag
stack_underflow  output  1  sticky flag

Behaviour:
- Reset (synchronous, has priority over stall and op):
  - uc_address = RESET_ADDR; depth = 0; counter = 0; count_zero = 1.
  - Both sticky flags = 0. Stack contents are don't-care.
  - A reset asserted during any sequence (call nesting, loop in progress) discards that state fully at the next edge.
- stall = 1 and reset = 0: no register changes, whatever the op.
- Condition: take = 1 if cond_sel == 0, else cond_in[cond_sel]. Then take is XORed with cond_invert (so cond_sel 0 with invert = never).
- inc = uc_address + 1, computed modulo 2^ADDR_WIDTH. Wrap from all-ones to 0 is legal and silent.
- Next state per op, one edge, zero added latency:
  - NEXT: uc_address <= inc.
  - JUMP: uc_address <= take ? din : inc.
  - CALL, take = 1: push inc; uc_address <= din; depth++.
  - CALL, take = 1, depth == STACK_DEPTH: uc_address <= din, no push, depth unchanged, stack_overflow <= 1.
  - CALL, take = 0: uc_address <= inc.
  - RETURN, take = 1, depth > 0: uc_address <= top of stack; pop; depth--.
  - RETURN, take = 1, depth == 0: uc_address <= inc; stack_underflow <= 1.
  - RETURN, take = 0: uc_address <= inc.
  - MAP: uc_address <= take ? map_in : inc.
  - LDCNT: counter <= din[COUNT_WIDTH-1:0]; uc_address <= inc. The condition is ignored.
  - LOOP, counter != 0: counter--; uc_address <= din. The condition is ignored.
  - LOOP, counter == 0: uc_address <= inc; counter stays 0.
  - HOLD: uc_address unchanged. Equivalent to a one-cycle stall of the address only; the counter and stack are unchanged.
- Stack is LIFO, implemented as a register array indexed by depth. Contents and depth are retained until the next CALL or RETURN.
- Sticky flags stay set until reset. Neither flag blocks further operation.
- count_zero and depth are combinational from registered state, so they are valid in the same cycle as uc_address.
- Ops are sampled only on the rising edge. Inputs need only meet setup relative to clock.

Test Plan:
- Reset with op = NEXT for 3 cycles, then release: uc_address goes 0, 1, 2, 3 on successive edges. depth = 0, count_zero = 1, both flags 0.
- JUMP din = 0x040 with cond_sel = 2: cond_in[2] = 1 gives 0x040. cond_in[2] = 0 gives inc. cond_invert = 1 swaps the two outcomes. cond_sel = 0 always jumps.
- Nested CALL from 0x010 to 0x100 and from 0x101 to 0x200, then RETURN twice: address 0x102 then 0x011, depth 2 → 1 → 0. With STACK_DEPTH = 4, a fifth CALL sets stack_overflow and still jumps. A RETURN at depth 0 sets stack_underflow and advances +1.
- LDCNT din = 3 at 0x020, then LOOP din = 0x021 at 0x021: body executes 4 times total, then falls through to 0x022 with count_zero = 1.
- MAP with map_in = 0x3A5 goes to 0x3A5. stall = 1 for 2 cycles mid-loop changes neither address nor counter. NEXT at 0xFFF wraps to 0x000.
- Reset asserted at depth 2 with counter 5 and stall = 1: next edge gives uc_address = RESET_ADDR, depth 0, counter 0, flags cleared.

Source files
------------

// File: rtl/uc_sequencer_p.sv
// Parametrised microcode sequencer: registered microaddress with conditional
// jump/call/return/map, a LIFO return stack, a hardware loop counter and stall.
module uc_sequencer_p #(
  parameter int ADDR_WIDTH  = 12,
  parameter int STACK_DEPTH = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int NUM_COND    = 8,
  parameter int RESET_ADDR  = 0,
  localparam int CSW = (NUM_COND > 1) ? $clog2(NUM_COND) : 1,
  localparam int DW  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [2:0]            op,
  input  logic [CSW-1:0]        cond_sel,
  input  logic                  cond_invert,
  input  logic [NUM_COND-1:0]   cond_in,
  input  logic [ADDR_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] map_in,
  output logic [ADDR_WIDTH-1:0] uc_address,
  output logic [DW-1:0]         depth,
  output logic                  count_zero,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_CALL   = 3'd2;
  localparam logic [2:0] OP_RETURN = 3'd3;
  localparam logic [2:0] OP_MAP    = 3'd4;
  localparam logic [2:0] OP_LDCNT  = 3'd5;
  localparam logic [2:0] OP_LOOP   = 3'd6;
  localparam logic [2:0] OP_HOLD   = 3'd7;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DW-1:0]          r_depth;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_ovf;
  logic                   r_unf;
  logic [ADDR_WIDTH-1:0]  r_stack [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0]  w_inc;
  logic                   w_take;
  logic [DW-1:0]          w_depth_m1;
  logic [SW-1:0]          w_push_idx;
  logic [SW-1:0]          w_pop_idx;
  logic                   w_push;
  logic [ADDR_WIDTH-1:0]  w_addr_nxt;
  logic [DW-1:0]          w_depth_nxt;
  logic [COUNT_WIDTH-1:0] w_count_nxt;
  logic                   w_ovf_nxt;
  logic                   w_unf_nxt;

  assign w_inc      = r_addr + ADDR_WIDTH'(1);
  assign w_depth_m1 = r_depth - DW'(1);
  assign w_push_idx = r_depth[SW-1:0];
  assign w_pop_idx  = w_depth_m1[SW-1:0];
  // cond_sel 0 is the hard-wired "always" condition; cond_in[0] is never used
  assign w_take     = ((cond_sel == CSW'(0)) ? 1'b1 : cond_in[cond_sel]) ^ cond_invert;

  always_comb begin
    w_addr_nxt  = r_addr;
    w_depth_nxt = r_depth;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    case (op)
      OP_NEXT: w_addr_nxt = w_inc;
      OP_JUMP: w_addr_nxt = w_take ? din : w_inc;
      OP_CALL: begin
        if (!w_take) begin
          w_addr_nxt = w_inc;
        end else if (r_depth == DW'(STACK_DEPTH)) begin
          // full stack: still jump, but the return address is lost
          w_addr_nxt = din;
          w_ovf_nxt  = 1'b1;
        end else begin
          w_addr_nxt  = din;
          w_push      = 1'b1;
          w_depth_nxt = r_depth + DW'(1);
        end
      end
      OP_RETURN: begin
        if (!w_take) begin
          w_addr_nxt = w_inc;
        end else if (r_depth == DW'(0)) begin
          w_addr_nxt = w_inc;
          w_unf_nxt  = 1'b1;
        end else begin
          w_addr_nxt  = r_stack[w_pop_idx];
          w_depth_nxt = w_depth_m1;
        end
      end
      OP_MAP: w_addr_nxt = w_take ? map_in : w_inc;
      OP_LDCNT: begin
        w_count_nxt = din[COUNT_WIDTH-1:0];
        w_addr_nxt  = w_inc;
      end
      OP_LOOP: begin
        if (r_count != COUNT_WIDTH'(0)) begin
          w_count_nxt = r_count - COUNT_WIDTH'(1);
          w_addr_nxt  = din;
        end else begin
          w_addr_nxt = w_inc;
        end
      end
      OP_HOLD: w_addr_nxt = r_addr;
      default: w_addr_nxt = r_addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= ADDR_WIDTH'(RESET_ADDR);
      r_depth <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_addr  <= w_addr_nxt;
      r_depth <= w_depth_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end else begin
      r_addr  <= r_addr;
    end
  end

  // Stack storage needs no reset: entries above depth are never read
  always_ff @(posedge clock) begin
    if (!reset && !stall && w_push) begin
      r_stack[w_push_idx] <= w_inc;
    end
  end

  assign uc_address      = r_addr;
  assign depth           = r_depth;
  assign count_zero      = (r_count == COUNT_WIDTH'(0));
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule
